mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Round-robin arbiter sharing one single-port valid/ready memory (WIDTH x DEPTH, 1-cycle read latency) between NUM_REQ requesters.
- Sits between requester masters and the memory's slave port; serialises transactions, routes read data back, and times out a stalled memory.
- One transaction outstanding at a time.

Parameters:
- NUM_REQ, 2, number of requesters (>=2).
- WIDTH, 32, data width.
- DEPTH, 1024, memory words; ADDR_WIDTH = $clog2(DEPTH).
- TIMEOUT_CYC, 16, max BUSY cycles awaiting mem_ready_i before abort.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid_i  in  NUM_REQ  per-requester request valid.
- req_wr_rd_i  in  NUM_REQ  1=write, 0=read.
- req_addr_i  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester k at [k*ADDR_WIDTH +: ADDR_WIDTH].
- req_wr_data_i  in  NUM_REQ*WIDTH  packed write data.
- req_ready_o  out  NUM_REQ  request accepted (handshake = valid & ready at clk edge).
- rsp_valid_o  out  NUM_REQ  one-cycle read-data strobe, one-hot.
- rsp_data_o  out  WIDTH  read data, valid with rsp_valid_o.
- err_o  out  NUM_REQ  one-cycle timeout strobe to the aborted requester.
- mem_valid_o  out  1  to memory valid_i.
- mem_wr_rd_o  out  1  to memory wr_rd_i.
- mem_addr_o  out  ADDR_WIDTH  to memory addr_i.
- mem_wr_data_o  out  WIDTH  to memory wr_data_i.
- mem_ready_i  in  1  from memory ready_o.
- mem_rd_data_i  in  WIDTH  from memory rd_data_o.

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0; grant register 0; last_grant=NUM_REQ-1, so requester 0 has top priority; timeout counter 0. Reset mid-transaction aborts it silently: no rsp/err strobe.
- Requesters hold valid and fields stable until req_ready_o; dropping valid early is illegal, no recovery is required.
- FSM states: IDLE, BUSY, RESP.
- IDLE: if any req_valid_i, pick the first set bit scanning from (last_grant+1) mod NUM_REQ upward with wrap. Register grant, go to BUSY. With no requests, stay in IDLE.
- BUSY:
  - mem_valid_o=1; mem_wr_rd_o/addr/wr_data are a combinational mux of the granted requester's inputs.
  - req_ready_o[grant]=mem_ready_i; all other ready bits are 0.
  - On mem_valid_o & mem_ready_i: last_grant<=grant. A write returns to IDLE; a read goes to RESP.
  - Timeout counter increments each BUSY cycle without mem_ready_i. At TIMEOUT_CYC: req_ready_o[grant]=1 for that cycle (completes the requester handshake), err_o[grant] pulses the next cycle, last_grant<=grant, return to IDLE. No memory access is issued.
- RESP: mem_valid_o=0. Sample mem_rd_data_i into rsp_data_o; rsp_valid_o[grant] is 1 the following cycle for exactly one cycle. Return to IDLE.
- Timed-out read: rsp_valid_o stays 0 and rsp_data_o holds its previous value.
- Latency from entering BUSY with memory ready: write 1 cycle; read data strobe 2 cycles after the accept edge. Throughput: write every 2 cycles, read every 3.
- Outside BUSY, mem_* outputs are 0.
- A grant holds until completion; new or higher-priority requests never pre-empt it.
- rsp_data_o and the error strobes are registered; err_o and rsp_valid_o are never both set in the same cycle.

Decomposition:
- Shared package mem_arb_pkg: state enum {IDLE,BUSY,RESP}, TIMEOUT counter width localparam, packed-field index helpers.
- One sub-module, rr_pick: purely combinational; inputs request vector and last_grant; outputs found flag and grant index.
- The FSM, muxes and counters stay in mem_arbiter.

Test Plan:
- Single requester 0 writes addr 5 = 0xDEADBEEF, then reads addr 5 -> req_ready_o[0] one cycle in BUSY; rsp_valid_o=2'b01 with rsp_data_o=0xDEADBEEF exactly 2 cycles after the read accept.
- Both requesters assert continuously after reset (req0 writes addr 0-3, req1 writes addr 512-515) -> grants alternate 0,1,0,1…; memory receives addr 0,512,1,513,…
- Memory ready_o held low 16 cycles with req1 reading -> req_ready_o[1] pulses at cycle 16, err_o[1] pulses next cycle, rsp_valid_o stays 0, next request is serviced normally.
- rst driven low while in BUSY on a read -> all outputs 0 immediately (async); no rsp_valid_o; after release requester 0 wins first.
- Full sweep: requester 0 writes $random to all 1024 addresses, requester 1 then reads all back -> 1024 rsp strobes to requester 1, data matching a scoreboard; address 1023 wraps cleanly to end.
- Simultaneous new request from req0 while req1 is in RESP -> req1 rsp completes undisturbed; req0 is granted in the following IDLE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and helpers for the round-robin memory arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int TIMEOUT_CYC_DEFAULT = 16;

  // Timeout counter holds 0..cyc-1; the abort fires on the cycle the count reaches cyc-1.
  function automatic int tmo_cnt_width(input int cyc);
    return (cyc < 2) ? 1 : $clog2(cyc);
  endfunction

  function automatic int field_lsb(input int idx, input int field_w);
    return idx * field_w;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// rtl/mem_arbiter_rr_pick.sv - combinational round-robin pick starting after last_grant
module rr_pick #(
  parameter int N  = 2,
  parameter int GW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] last,
  output logic          found,
  output logic [GW-1:0] idx
);

  always_comb begin
    int k;
    logic [GW-1:0] ki;
    found = 1'b0;
    idx   = '0;
    k     = 0;
    ki    = '0;
    for (int i = 1; i <= N; i++) begin
      k  = (int'(last) + i) % N;
      ki = GW'(k);
      if (!found && req[ki]) begin
        found = 1'b1;
        idx   = ki;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one valid/ready memory between requesters
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 1024,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT,
  parameter int ADDR_WIDTH  = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ-1:0]            req_wr_rd_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*WIDTH-1:0]      req_wr_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [NUM_REQ-1:0]            rsp_valid_o,
  output logic [WIDTH-1:0]              rsp_data_o,
  output logic [NUM_REQ-1:0]            err_o,
  output logic                          mem_valid_o,
  output logic                          mem_wr_rd_o,
  output logic [ADDR_WIDTH-1:0]         mem_addr_o,
  output logic [WIDTH-1:0]              mem_wr_data_o,
  input  logic                          mem_ready_i,
  input  logic [WIDTH-1:0]              mem_rd_data_i
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = tmo_cnt_width(TIMEOUT_CYC);

  state_t        state, state_nxt;
  logic [GW-1:0] grant;
  logic [GW-1:0] last_grant;
  logic [CW-1:0] tmo_cnt;
  logic          pick_found;
  logic [GW-1:0] pick_idx;
  logic          mem_hs;
  logic          tmo_hit;
  logic          grant_wr;

  rr_pick #(
    .N  (NUM_REQ),
    .GW (GW)
  ) u_rr_pick (
    .req   (req_valid_i),
    .last  (last_grant),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign grant_wr = req_wr_rd_i[grant];
  assign mem_hs   = (state == BUSY) && mem_ready_i;
  assign tmo_hit  = (state == BUSY) && !mem_ready_i && (tmo_cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (pick_found) state_nxt = BUSY;
      BUSY: begin
        if (mem_hs) state_nxt = grant_wr ? IDLE : RESP;
        else if (tmo_hit) state_nxt = IDLE;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory-side signals are a pure mux of the held grant, so they only toggle while BUSY.
  always_comb begin
    req_ready_o   = '0;
    mem_valid_o   = 1'b0;
    mem_wr_rd_o   = 1'b0;
    mem_addr_o    = '0;
    mem_wr_data_o = '0;
    if (state == BUSY) begin
      mem_valid_o        = 1'b1;
      mem_wr_rd_o        = grant_wr;
      mem_addr_o         = req_addr_i[field_lsb(int'(grant), ADDR_WIDTH) +: ADDR_WIDTH];
      mem_wr_data_o      = req_wr_data_i[field_lsb(int'(grant), WIDTH) +: WIDTH];
      req_ready_o[grant] = mem_ready_i | tmo_hit;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant       <= '0;
      last_grant  <= GW'(NUM_REQ - 1);
      tmo_cnt     <= '0;
      rsp_data_o  <= '0;
      rsp_valid_o <= '0;
      err_o       <= '0;
    end else begin
      rsp_valid_o <= '0;
      err_o       <= '0;
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (pick_found) grant <= pick_idx;
        end
        BUSY: begin
          if (mem_hs) begin
            last_grant <= grant;
            tmo_cnt    <= '0;
          end else if (tmo_hit) begin
            last_grant   <= grant;
            tmo_cnt      <= '0;
            err_o[grant] <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
          end
        end
        RESP: begin
          rsp_data_o         <= mem_rd_data_i;
          rsp_valid_o[grant] <= 1'b1;
        end
        default: tmo_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a behavioural memory
module tb_mem_arbiter;

  localparam int NR  = 2;
  localparam int W   = 32;
  localparam int D   = 1024;
  localparam int AW  = 10;
  localparam int TMO = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid, req_wr_rd, req_ready, rsp_valid, err;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*W-1:0]   req_wr_data;
  logic [W-1:0]      rsp_data;
  logic              mem_valid, mem_wr_rd, mem_ready;
  logic [AW-1:0]     mem_addr;
  logic [W-1:0]      mem_wr_data, mem_rd;

  logic              rv [NR];
  logic              rw [NR];
  logic [AW-1:0]     ra [NR];
  logic [W-1:0]      rd [NR];

  logic [W-1:0]      mem [D];
  logic [W-1:0]      ref_mem [D];
  logic [W-1:0]      exp_q [NR][$];
  int                mem_log [$];
  int                rsp_cnt [NR];
  int                err_cnt [NR];
  logic              mem_stall;
  int                checks = 0;
  int                errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NR; g++) begin : g_pack
    assign req_valid[g]             = rv[g];
    assign req_wr_rd[g]             = rw[g];
    assign req_addr[g*AW +: AW]     = ra[g];
    assign req_wr_data[g*W +: W]    = rd[g];
  end

  assign mem_ready = !mem_stall;

  mem_arbiter #(
    .NUM_REQ     (NR),
    .WIDTH       (W),
    .DEPTH       (D),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid_i   (req_valid),
    .req_wr_rd_i   (req_wr_rd),
    .req_addr_i    (req_addr),
    .req_wr_data_i (req_wr_data),
    .req_ready_o   (req_ready),
    .rsp_valid_o   (rsp_valid),
    .rsp_data_o    (rsp_data),
    .err_o         (err),
    .mem_valid_o   (mem_valid),
    .mem_wr_rd_o   (mem_wr_rd),
    .mem_addr_o    (mem_addr),
    .mem_wr_data_o (mem_wr_data),
    .mem_ready_i   (mem_ready),
    .mem_rd_data_i (mem_rd)
  );

  // Single-port memory, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_valid && !mem_stall) begin
      if (mem_wr_rd) mem[mem_addr] <= mem_wr_data;
      else mem_rd <= mem[mem_addr];
      mem_log.push_back(int'(mem_addr));
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && (rsp_valid != '0 || err != '0)) begin
      check("rsp_err_excl", 64'((|rsp_valid) && (|err)), 0);
      check("rsp_onehot", 64'($onehot0(rsp_valid)), 1);
      for (int k = 0; k < NR; k++) begin
        if (err[k]) err_cnt[k]++;
        if (rsp_valid[k]) begin
          rsp_cnt[k]++;
          if (exp_q[k].size() == 0) check("rsp_unexp", rsp_valid, 0);
          else check($sformatf("rsp_data_req%0d", k), rsp_data, exp_q[k].pop_front());
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_req(input int k, input bit wr, input int addr, input logic [W-1:0] data,
                        input bit push, output int waits, output bit ok);
    rv[k] = 1'b1;
    rw[k] = wr;
    ra[k] = AW'(addr);
    rd[k] = data;
    if (wr) ref_mem[addr] = data;
    else if (push) exp_q[k].push_back(ref_mem[addr]);
    waits = 0;
    ok    = 1'b0;
    while (!ok && waits < 64) begin
      @(negedge clk);
      waits++;
      ok = req_ready[k];
    end
    check($sformatf("hs_req%0d", k), 64'(ok), 1);
    @(posedge clk);
    #1;
    rv[k] = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w;
    bit ok;
    int sz;
    int base;
    rst       = 1'b0;
    mem_stall = 1'b0;
    for (int k = 0; k < NR; k++) begin
      rv[k] = 1'b0; rw[k] = 1'b0; ra[k] = '0; rd[k] = '0;
      rsp_cnt[k] = 0; err_cnt[k] = 0;
    end
    idle(3);
    check("rst_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_err", err, 0);
    check("rst_mem_valid", mem_valid, 0);
    check("rst_mem_addr", mem_addr, 0);
    rst = 1'b1;
    idle(1);

    // Single requester write then read-back with latency checks
    do_req(0, 1, 5, 32'hDEADBEEF, 1, w, ok);
    check("t1_wr_wait", w, 2);
    do_req(0, 0, 5, '0, 1, w, ok);
    check("t1_rd_wait", w, 2);
    @(negedge clk);
    check("t1_ready_pulse", req_ready, 0);
    check("t1_rsp_early", rsp_valid, 0);
    @(negedge clk);
    check("t1_rsp_strobe", rsp_valid, 2'b01);
    check("t1_rsp_data", rsp_data, 32'hDEADBEEF);
    idle(2);

    // Fresh reset so requester 0 has priority, then both contend
    rst = 1'b0;
    idle(1);
    rst = 1'b1;
    sz = mem_log.size();
    fork
      begin
        int wa; bit oa;
        for (int i = 0; i < 4; i++) do_req(0, 1, i, $urandom, 1, wa, oa);
      end
      begin
        int wb; bit ob;
        for (int i = 0; i < 4; i++) do_req(1, 1, 512 + i, $urandom, 1, wb, ob);
      end
    join
    check("t2_log_len", mem_log.size() - sz, 8);
    for (int i = 0; i < 8; i++)
      check($sformatf("t2_order%0d", i), mem_log[sz+i], (i % 2 == 0) ? i / 2 : 512 + i / 2);
    idle(2);

    // Stalled memory: timeout on a read from requester 1
    do_req(1, 0, 512, '0, 1, w, ok);
    idle(3);
    sz = mem_log.size();
    mem_stall = 1'b1;
    do_req(1, 0, 513, '0, 0, w, ok);
    check("t3_tmo_wait", w, TMO + 1);
    mem_stall = 1'b0;
    @(negedge clk);
    check("t3_err", err, 2'b10);
    check("t3_rsp_none", rsp_valid, 0);
    @(negedge clk);
    check("t3_err_once", err, 0);
    check("t3_rsp_hold", rsp_data, ref_mem[512]);
    check("t3_no_access", mem_log.size() - sz, 0);
    @(posedge clk);
    #1;
    do_req(1, 0, 514, '0, 1, w, ok);
    check("t3_recover_wait", w, 2);
    idle(3);
    check("t3_err_cnt", err_cnt[1], 1);

    // Asynchronous reset while a read is stuck in BUSY
    mem_stall = 1'b1;
    rv[1] = 1'b1; rw[1] = 1'b0; ra[1] = AW'(600);
    repeat (3) @(negedge clk);
    check("t4_busy", mem_valid, 1);
    rst = 1'b0;
    #1;
    check("t4_mem_valid", mem_valid, 0);
    check("t4_mem_addr", mem_addr, 0);
    check("t4_ready", req_ready, 0);
    check("t4_rsp_valid", rsp_valid, 0);
    check("t4_err", err, 0);
    check("t4_rsp_data", rsp_data, 0);
    rv[1] = 1'b0;
    idle(2);
    rst = 1'b1;
    mem_stall = 1'b0;
    idle(4);
    check("t4_no_err", err_cnt[1], 1);
    sz = mem_log.size();
    fork
      begin int wa; bit oa; do_req(0, 0, 1, '0, 1, wa, oa); end
      begin int wb; bit ob; do_req(1, 0, 513, '0, 1, wb, ob); end
    join
    check("t4_first", mem_log[sz], 1);
    check("t4_second", mem_log[sz+1], 513);
    idle(3);

    // Full sweep: requester 0 fills, requester 1 reads back
    base = rsp_cnt[1];
    sz = mem_log.size();
    for (int a = 0; a < D; a++) do_req(0, 1, a, $urandom, 1, w, ok);
    for (int a = 0; a < D; a++) do_req(1, 0, a, '0, 1, w, ok);
    idle(3);
    check("t5_rsp_cnt", rsp_cnt[1] - base, D);
    check("t5_log_cnt", mem_log.size() - sz, 2 * D);
    check("t5_last_addr", mem_log[mem_log.size()-1], D - 1);

    // New request from requester 0 while requester 1 is in RESP
    do_req(1, 0, 700, '0, 1, w, ok);
    do_req(0, 0, 10, '0, 1, w, ok);
    check("t6_wait", w, 3);
    check("t6_prev", mem_log[mem_log.size()-2], 700);
    check("t6_grant", mem_log[mem_log.size()-1], 10);
    idle(4);
    for (int k = 0; k < NR; k++) check($sformatf("drain_req%0d", k), exp_q[k].size(), 0);
    check("total_err", err_cnt[0] + err_cnt[1], 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
